// File: rtl/mod12_seq_monitor_if.sv
// Bus between the upstream mod-12 counter and the mod12_seq_monitor.
// master: drives the counter sample and load strobe and observes the results.
// slave:  the monitor itself, which samples the inputs and drives the registered outputs.
interface mod12_seq_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic [3:0]       q_in;
    logic             load_in;
    logic             wrap_pulse;
    logic [CNT_W-1:0] wrap_cnt;
    logic             jump_err;
    logic             range_err;
    logic [1:0]       state;

    modport master (
        output q_in,
        output load_in,
        input  wrap_pulse,
        input  wrap_cnt,
        input  jump_err,
        input  range_err,
        input  state
    );

    modport slave (
        input  q_in,
        input  load_in,
        output wrap_pulse,
        output wrap_cnt,
        output jump_err,
        output range_err,
        output state
    );
endinterface

// File: rtl/mod12_seq_monitor.sv
// Watches the output of a mod-12 up counter and checks that it steps 0..11 in order.
// Counts legal 11->0 wraps (saturating), flags out-of-range samples and, optionally,
// non-sequential steps that were not announced by a load strobe.
// Optional feature: define MOD12_SEQ_MONITOR_JUMP_DET_EN to build in jump detection;
// without it jump_err is tied low and a bad step just re-baselines the tracker.
// All outputs come straight from registers, one cycle after the sample that caused them.
module mod12_seq_monitor #(
    parameter int unsigned CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    mod12_seq_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        StSync  = 2'b00,
        StTrack = 2'b01,
        StFault = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    // load strobe seen on the previous edge: the counter shows the loaded value one edge later
    logic             load_q;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             range_err_q, range_err_d;
`ifdef MOD12_SEQ_MONITOR_JUMP_DET_EN
    logic             jump_err_q, jump_err_d;
`endif

    logic [3:0] expected;
    logic       in_range;
    logic       cnt_sat;

    assign expected = (prev_q == 4'd11) ? 4'd0 : prev_q + 4'd1;
    assign in_range = (mon.q_in <= 4'd11);
    assign cnt_sat  = &wrap_cnt_q;

    // Next-state and next-output decode; everything defaults to hold, wrap_pulse to 0.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        wrap_pulse_d = 1'b0;
        wrap_cnt_d   = wrap_cnt_q;
        range_err_d  = range_err_q;
`ifdef MOD12_SEQ_MONITOR_JUMP_DET_EN
        jump_err_d   = jump_err_q;
`endif
        case (state_q)
            StSync: begin
                // First sample establishes the baseline, even if it is out of range.
                prev_d = mon.q_in;
                if (in_range) begin
                    state_d = StTrack;
                end else begin
                    state_d     = StFault;
                    range_err_d = 1'b1;
                end
            end
            StTrack: begin
                if (!in_range) begin
                    // Range check wins over any sequence check on the same sample.
                    state_d     = StFault;
                    range_err_d = 1'b1;
                end else if (load_q) begin
                    prev_d = mon.q_in;
                end else if (mon.q_in == expected) begin
                    prev_d = mon.q_in;
                    if (prev_q == 4'd11) begin
                        wrap_pulse_d = 1'b1;
                        if (!cnt_sat) begin
                            wrap_cnt_d = wrap_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    prev_d = mon.q_in;
`ifdef MOD12_SEQ_MONITOR_JUMP_DET_EN
                    jump_err_d = 1'b1;
`endif
                end
            end
            StFault: begin
                // Everything frozen until the upstream counter is reloaded.
                if (mon.load_in) begin
                    state_d = StSync;
                end
            end
            default: begin
                state_d = StSync;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StSync;
            prev_q       <= 4'd0;
            load_q       <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
            range_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            load_q       <= mon.load_in;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
            range_err_q  <= range_err_d;
        end
    end

`ifdef MOD12_SEQ_MONITOR_JUMP_DET_EN
    // Sticky jump flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            jump_err_q <= 1'b0;
        end else begin
            jump_err_q <= jump_err_d;
        end
    end

    assign mon.jump_err = jump_err_q;
`else
    assign mon.jump_err = 1'b0;
`endif

    assign mon.state      = state_q;
    assign mon.wrap_pulse = wrap_pulse_q;
    assign mon.wrap_cnt   = wrap_cnt_q;
    assign mon.range_err  = range_err_q;

endmodule

// File: tb/tb_mod12_seq_monitor.sv
// Directed bench for mod12_seq_monitor: a default-width instance and a CNT_W=2 instance
// receive identical stimulus; expected values are written out by hand per step.
module tb_mod12_seq_monitor;

`ifdef MOD12_SEQ_MONITOR_JUMP_DET_EN
    localparam logic JD = 1'b1;
`else
    localparam logic JD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mod12_seq_monitor_if #(.CNT_W(8)) bus ();
    mod12_seq_monitor_if #(.CNT_W(2)) bus2 ();

    mod12_seq_monitor #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    mod12_seq_monitor #(.CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .mon (bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One edge with rst low; inputs change on the falling edge, outputs sampled 1 after rising.
    task automatic step(input logic [3:0] q, input logic ld);
        @(negedge clk);
        rst          = 1'b0;
        bus.q_in     = q;
        bus.load_in  = ld;
        bus2.q_in    = q;
        bus2.load_in = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_step(input logic [3:0] q, input logic ld);
        @(negedge clk);
        rst          = 1'b1;
        bus.q_in     = q;
        bus.load_in  = ld;
        bus2.q_in    = q;
        bus2.load_in = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic pulse,
                             input logic [7:0] cnt, input logic jerr, input logic rerr);
        check({tag, ".state"}, {14'd0, bus.state}, {14'd0, st});
        check({tag, ".pulse"}, {15'd0, bus.wrap_pulse}, {15'd0, pulse});
        check({tag, ".cnt"}, {8'd0, bus.wrap_cnt}, {8'd0, cnt});
        check({tag, ".jump"}, {15'd0, bus.jump_err}, {15'd0, jerr});
        check({tag, ".range"}, {15'd0, bus.range_err}, {15'd0, rerr});
    endtask

    initial begin
        bus.q_in = 4'd0; bus.load_in = 1'b0; bus2.q_in = 4'd0; bus2.load_in = 1'b0;

        // Reset state
        rst_step(4'd5, 1'b1);
        check_all("reset", 2'b00, 1'b0, 8'd0, 1'b0, 1'b0);
        check("reset.cnt2", {14'd0, bus2.wrap_cnt}, 16'd0);

        // Clean count 0..11,0,1: a single pulse right after the wrapping 0 sample
        for (int i = 0; i < 14; i++) begin
            step(4'((i < 12) ? i : i - 12), 1'b0);
            check($sformatf("seq%0d.pulse", i), {15'd0, bus.wrap_pulse}, {15'd0, (i == 12)});
        end
        check_all("seq_end", 2'b01, 1'b0, 8'd1, 1'b0, 1'b0);
        check("seq_end.cnt2", {14'd0, bus2.wrap_cnt}, 16'd1);

        // Jump 5 -> 9 without load, then 10,11,0 still wraps
        step(4'd2, 1'b0); step(4'd3, 1'b0); step(4'd4, 1'b0); step(4'd5, 1'b0);
        check("pre_jump.jump", {15'd0, bus.jump_err}, 16'd0);
        step(4'd9, 1'b0);
        check_all("jump", 2'b01, 1'b0, 8'd1, JD, 1'b0);
        step(4'd10, 1'b0); step(4'd11, 1'b0);
        check("jump_hold.jump", {15'd0, bus.jump_err}, {15'd0, JD});
        step(4'd0, 1'b0);
        check_all("jump_wrap", 2'b01, 1'b1, 8'd2, JD, 1'b0);

        // Load announced at sample 3, then 7 and 8 are accepted
        rst_step(4'd0, 1'b0);
        check_all("reset2", 2'b00, 1'b0, 8'd0, 1'b0, 1'b0);
        step(4'd0, 1'b0); step(4'd1, 1'b0); step(4'd2, 1'b0);
        step(4'd3, 1'b1);
        step(4'd7, 1'b0);
        check("load7.jump", {15'd0, bus.jump_err}, 16'd0);
        step(4'd8, 1'b0);
        check("load8.jump", {15'd0, bus.jump_err}, 16'd0);
        step(4'd9, 1'b0); step(4'd10, 1'b0);
        // Load at 11: the following 0 is a new baseline, not a wrap
        step(4'd11, 1'b1);
        step(4'd0, 1'b0);
        check_all("load_nowrap", 2'b01, 1'b0, 8'd0, 1'b0, 1'b0);
        step(4'd1, 1'b0);
        check("after_load.jump", {15'd0, bus.jump_err}, 16'd0);

        // Out of range 13 (also a jump): only range_err, FAULT freezes counting
        step(4'd13, 1'b0);
        check_all("range", 2'b10, 1'b0, 8'd0, 1'b0, 1'b1);
        step(4'd11, 1'b0); step(4'd0, 1'b0); step(4'd11, 1'b0); step(4'd0, 1'b0);
        check_all("fault_frozen", 2'b10, 1'b0, 8'd0, 1'b0, 1'b1);
        step(4'd5, 1'b1);
        check_all("fault_load", 2'b00, 1'b0, 8'd0, 1'b0, 1'b1);
        step(4'd6, 1'b0);
        check("resync.state", {14'd0, bus.state}, 16'd1);
        step(4'd7, 1'b0);
        check_all("resync_track", 2'b01, 1'b0, 8'd0, 1'b0, 1'b1);

        // Jump then fault, then reset mid-FAULT with load high
        step(4'd9, 1'b0);
        check("jump2.jump", {15'd0, bus.jump_err}, {15'd0, JD});
        step(4'd14, 1'b0);
        check_all("fault2", 2'b10, 1'b0, 8'd0, JD, 1'b1);
        rst_step(4'd3, 1'b1);
        check_all("reset_fault", 2'b00, 1'b0, 8'd0, 1'b0, 1'b0);

        // Five full cycles: narrow counter saturates at 3 but keeps pulsing
        for (int n = 0; n <= 60; n++) begin
            step(4'(n % 12), 1'b0);
            if (n > 0 && (n % 12) == 0) begin
                check($sformatf("sat%0d.cnt8", n / 12), {8'd0, bus.wrap_cnt}, 16'(n / 12));
                check($sformatf("sat%0d.cnt2", n / 12), {14'd0, bus2.wrap_cnt},
                      16'((n / 12 > 3) ? 3 : n / 12));
                check($sformatf("sat%0d.pulse2", n / 12), {15'd0, bus2.wrap_pulse}, 16'd1);
            end
        end
        step(4'd1, 1'b0);
        check("sat_end.pulse2", {15'd0, bus2.wrap_pulse}, 16'd0);
        check("sat_end.cnt2", {14'd0, bus2.wrap_cnt}, 16'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod12_seq_monitor.md
MOD12_SEQ_MONITOR -- requirements
Module: mod12_seq_monitor

Interface
REQ-001 Parameter: CNT_W, 8, width of wrap_cnt; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 q_in  input  4  count value from the upstream mod-12 up counter, sampled every rising edge.
REQ-005 load_in  input  1  upstream load strobe, same cycle alignment as the counter's load input.
REQ-006 wrap_pulse  output  1  one-cycle pulse per legal 11->0 transition.
REQ-007 wrap_cnt  output  CNT_W  number of legal wraps since reset, saturating.
REQ-008 jump_err  output  1  sticky flag: non-sequential step without a preceding load.
REQ-009 range_err  output  1  sticky flag: q_in sampled above 11.
REQ-010 state  output  2  FSM state: 00 SYNC, 01 TRACK, 10 FAULT.

Function
REQ-011 The block SHALL hold registers prev_q[3:0] (last sample) and load_d (load_in from the previous edge).
REQ-012 The block SHALL compute expected = 0 when prev_q==11, else prev_q+1, in 4-bit arithmetic.
REQ-013 SYNC: on the next edge, capture q_in into prev_q; go to TRACK if q_in<=11, else to FAULT and set range_err.
REQ-014 TRACK, q_in>11: go to FAULT, set range_err; prev_q unchanged.
REQ-015 TRACK, load_d==1: accept q_in as the new baseline with no sequence check and no wrap.
REQ-016 TRACK, load_d==0, q_in==expected: update prev_q; if prev_q==11, assert wrap_pulse on the following cycle and increment wrap_cnt.
REQ-017 TRACK, load_d==0, q_in!=expected: set jump_err, take q_in as the new baseline, stay in TRACK.
REQ-018 wrap_cnt SHALL saturate at 2^CNT_W-1; wrap_pulse still asserts at saturation.
REQ-019 FAULT: prev_q, wrap_cnt and jump_err frozen; wrap_pulse held 0.
REQ-020 FAULT: load_in sampled 1 goes to SYNC; range_err stays set.
REQ-021 All outputs SHALL be registered; latency from sampled q_in to flag or pulse is exactly one cycle.
REQ-022 If a range violation and a jump occur on the same sample, only range_err SHALL set (range check takes priority).

Reset
REQ-023 rst high at an edge SHALL force state=SYNC, prev_q=0, load_d=0, wrap_pulse=0, wrap_cnt=0, jump_err=0, range_err=0, regardless of FSM state.
REQ-024 rst SHALL take priority over load_in and q_in in the same cycle; the first sample is taken on the first edge with rst low.

Configuration
REQ-025 Macro MOD12_SEQ_MONITOR_JUMP_DET_EN: when defined, jump detection per REQ-017 SHALL be compiled in.
REQ-026 When undefined, jump_err SHALL be tied 0 and REQ-017 reduces to a baseline update; wraps count only when q_in==expected.

Verification
REQ-027 rst 1 cycle, then q_in 0,1,...,11,0,1 with load_in=0 -> wrap_pulse once, 1 cycle after the 0 sample; wrap_cnt=1; no errors.
REQ-028 TRACK at prev_q=5, q_in=9 with load_d=0 -> jump_err=1 next cycle and stays set; then 10,11,0 -> wrap_cnt increments.
REQ-029 load_in=1 with prev_q=3, next q_in=7 -> no jump_err; next q_in=8 is accepted as sequential.
REQ-030 q_in=13 in TRACK -> range_err=1, state=10; further 11->0 steps leave wrap_cnt unchanged; load_in=1 -> state=00.
REQ-031 CNT_W=2, 5 full cycles -> wrap_cnt=3 after the third wrap and held; wrap_pulse still fires on wraps 4 and 5.
REQ-032 rst asserted mid-FAULT with range_err=1, jump_err=1 -> all outputs 0 and state=00 after that edge; rerun of REQ-027 with the macro undefined and a 5->9 jump -> jump_err stays 0.
